vote_tally_reader: RTL and testbench

Result-mode controller that sits in front of `votingMachine` and drives its `mode`/`button1..4` inputs to read out all four candidate tallies from `led`. It presses each candidate button in turn, samples the displayed count after a fixed settle time, and streams the four counts out on a valid/ready port. It also reports the winner and a tie flag. It is the reading end of the machine's button/LED result interface and replaces manual button-driving in result mode.

---
 rtl/vote_pkg.sv | 21 ++
 rtl/vote_tally_reader_if.sv | 23 ++
 rtl/tally_max_tracker.sv | 47 ++++
 rtl/vote_tally_reader.sv | 177 +++++++++++++++++
 tb/tb_vote_tally_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the votingMachine result-mode reader.
package vote_pkg;

  localparam int NUM_CANDIDATES = 4;
  localparam int COUNT_W        = 8;

  typedef logic [1:0] cand_idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EMIT   = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } tally_state_t;

  function automatic logic [NUM_CANDIDATES-1:0] button_onehot(input cand_idx_t k);
    return 4'b0001 << k;
  endfunction

endpackage

// File: rtl/vote_tally_reader_if.sv
// Valid/ready stream carrying one captured tally per candidate.
interface vote_tally_reader_if;

  logic                               tally_valid;
  logic                               tally_ready;
  vote_pkg::cand_idx_t                tally_idx;
  logic [vote_pkg::COUNT_W-1:0]       tally_count;

  modport master (
    output tally_valid,
    output tally_idx,
    output tally_count,
    input  tally_ready
  );

  modport slave (
    input  tally_valid,
    input  tally_idx,
    input  tally_count,
    output tally_ready
  );

endinterface

// File: rtl/tally_max_tracker.sv
// Running maximum over the streamed tallies; lowest index wins on a tie.
module tally_max_tracker
  import vote_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  cand_idx_t          idx,
  input  logic [COUNT_W-1:0] count,
  output cand_idx_t          winner,
  output logic               tie
);

  logic [COUNT_W-1:0] r_max;
  cand_idx_t          r_winner;
  logic               r_tie;

  // max/winner/tie registers; the first candidate always seeds the maximum
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_max    <= {COUNT_W{1'b0}};
      r_winner <= 2'd0;
      r_tie    <= 1'b0;
    end else if (clear) begin
      r_max    <= {COUNT_W{1'b0}};
      r_winner <= 2'd0;
      r_tie    <= 1'b0;
    end else if (update) begin
      if ((idx == 2'd0) || (count > r_max)) begin
        r_max    <= count;
        r_winner <= idx;
        r_tie    <= 1'b0;
      end else if (count == r_max) begin
        r_tie    <= 1'b1;
      end else begin
        r_tie    <= r_tie;
      end
    end else begin
      r_max    <= r_max;
    end
  end

  assign winner = r_winner;
  assign tie    = r_tie;

endmodule

// File: rtl/vote_tally_reader.sv
// Drives votingMachine result mode: presses each candidate button, samples led,
// streams the four counts and reports winner/tie.
module vote_tally_reader
  import vote_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2
)
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      vm_mode,
  output logic                      vm_button1,
  output logic                      vm_button2,
  output logic                      vm_button3,
  output logic                      vm_button4,
  input  logic [COUNT_W-1:0]        vm_led,
  vote_tally_reader_if.master       tally,
  output logic                      winner_valid,
  output cand_idx_t                 winner,
  output logic                      tie
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam cand_idx_t        LAST_IDX    = cand_idx_t'(NUM_CANDIDATES - 1);

  tally_state_t               r_state;
  cand_idx_t                  r_k;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_mode;
  logic [NUM_CANDIDATES-1:0]  r_buttons;
  logic                       r_valid;
  cand_idx_t                  r_idx;
  logic [COUNT_W-1:0]         r_count;
  logic                       r_winner_valid;

  tally_state_t               w_next_state;
  cand_idx_t                  w_next_k;
  logic [CNT_W-1:0]           w_next_cnt;
  logic                       w_capture;
  logic                       w_handshake;
  logic                       w_clear;

  // next-state, candidate index and settle/gap down-counter
  always_comb begin
    w_next_state = r_state;
    w_next_k     = r_k;
    w_next_cnt   = r_cnt;
    w_capture    = 1'b0;
    w_handshake  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SELECT;
          w_next_k     = 2'd0;
          w_next_cnt   = SETTLE_LOAD;
          w_clear      = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      SELECT: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_next_state = EMIT;
          w_capture    = 1'b1;
        end else begin
          w_next_cnt   = r_cnt - CNT_ONE;
        end
      end
      EMIT: begin
        if (r_valid && tally.tally_ready) begin
          w_handshake = 1'b1;
          if (r_k == LAST_IDX) begin
            w_next_state = DONE;
          end else if (GAP_CYCLES == 0) begin
            w_next_state = SELECT;
            w_next_k     = r_k + 2'd1;
            w_next_cnt   = SETTLE_LOAD;
          end else begin
            w_next_state = GAP;
            w_next_cnt   = GAP_LOAD;
          end
        end else begin
          w_next_state = EMIT;
        end
      end
      GAP: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_next_state = SELECT;
          w_next_k     = r_k + 2'd1;
          w_next_cnt   = SETTLE_LOAD;
        end else begin
          w_next_cnt   = r_cnt - CNT_ONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // state plus outputs registered from the upcoming state so they align with it
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_k            <= 2'd0;
      r_cnt          <= {CNT_W{1'b0}};
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_mode         <= 1'b0;
      r_buttons      <= {NUM_CANDIDATES{1'b0}};
      r_valid        <= 1'b0;
      r_idx          <= 2'd0;
      r_count        <= {COUNT_W{1'b0}};
      r_winner_valid <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_k       <= w_next_k;
      r_cnt     <= w_next_cnt;
      r_busy    <= (w_next_state != IDLE);
      r_done    <= (w_next_state == DONE);
      r_mode    <= (w_next_state == SELECT) || (w_next_state == EMIT) || (w_next_state == GAP);
      r_buttons <= (w_next_state == SELECT) ? button_onehot(w_next_k) : {NUM_CANDIDATES{1'b0}};
      r_valid   <= (w_next_state == EMIT);
      if (w_capture) begin
        r_idx   <= r_k;
        r_count <= vm_led;
      end else begin
        r_idx   <= r_idx;
        r_count <= r_count;
      end
      if (w_clear) begin
        r_winner_valid <= 1'b0;
      end else if (w_next_state == DONE) begin
        r_winner_valid <= 1'b1;
      end else begin
        r_winner_valid <= r_winner_valid;
      end
    end
  end

  tally_max_tracker u_tracker (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_clear),
    .update (w_handshake),
    .idx    (r_idx),
    .count  (r_count),
    .winner (winner),
    .tie    (tie)
  );

  assign busy              = r_busy;
  assign done              = r_done;
  assign vm_mode           = r_mode;
  assign vm_button1        = r_buttons[0];
  assign vm_button2        = r_buttons[1];
  assign vm_button3        = r_buttons[2];
  assign vm_button4        = r_buttons[3];
  assign tally.tally_valid = r_valid;
  assign tally.tally_idx   = r_idx;
  assign tally.tally_count = r_count;
  assign winner_valid      = r_winner_valid;

endmodule

// File: tb/tb_vote_tally_reader.sv
// Directed bench for vote_tally_reader against a behavioural votingMachine result-mode model.
module tb_vote_tally_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, vm_mode;
  logic       vm_button1, vm_button2, vm_button3, vm_button4;
  logic [7:0] vm_led = 8'd0;
  logic       winner_valid, tie;
  logic [1:0] winner;
  logic [7:0] vm_tally [4];

  int n_vec   = 0;
  int n_err   = 0;
  int mon_bad = 0;

  logic [1:0] x_idx [4];
  logic [7:0] x_cnt [4];
  int         n_xfer;

  vote_tally_reader_if u_if ();

  vote_tally_reader #(.SETTLE_CYCLES(4), .GAP_CYCLES(2)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .vm_mode      (vm_mode),
    .vm_button1   (vm_button1),
    .vm_button2   (vm_button2),
    .vm_button3   (vm_button3),
    .vm_button4   (vm_button4),
    .vm_led       (vm_led),
    .tally        (u_if),
    .winner_valid (winner_valid),
    .winner       (winner),
    .tie          (tie)
  );

  always #5 clock = ~clock;

  // votingMachine in result mode: led shows the pressed candidate's tally one edge later
  always @(posedge clock) begin
    if (vm_mode && vm_button1)      vm_led <= vm_tally[0];
    else if (vm_mode && vm_button2) vm_led <= vm_tally[1];
    else if (vm_mode && vm_button3) vm_led <= vm_tally[2];
    else if (vm_mode && vm_button4) vm_led <= vm_tally[3];
    else                            vm_led <= 8'd0;
  end

  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [1:0] p_idx   = 2'd0;
  logic [7:0] p_cnt   = 8'd0;

  // protocol monitor: one-hot buttons, no button during EMIT, stream stable under stall
  always @(posedge clock) begin
    if (reset) begin
      mon_bad <= mon_bad
               + int'($countones({vm_button4, vm_button3, vm_button2, vm_button1}) > 1)
               + int'(u_if.tally_valid && ({vm_button4, vm_button3, vm_button2, vm_button1} != 4'd0))
               + int'(p_valid && !p_ready &&
                      (!u_if.tally_valid || (u_if.tally_idx != p_idx) || (u_if.tally_count != p_cnt)));
      p_valid <= u_if.tally_valid;
      p_ready <= u_if.tally_ready;
      p_idx   <= u_if.tally_idx;
      p_cnt   <= u_if.tally_count;
    end else begin
      p_valid <= 1'b0;
      p_ready <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2,
                          input logic [7:0] t3, input int exp_done, input logic [1:0] exp_w,
                          input logic exp_tie, input bit stall, input bit pulse);
    logic [7:0] exp_t [4];
    int done_cyc;
    int stall_left;
    exp_t = '{t0, t1, t2, t3};
    vm_tally = '{t0, t1, t2, t3};
    n_xfer = 0;
    done_cyc = 0;
    stall_left = stall ? 5 : 0;
    @(negedge clock);
    start = 1'b1;
    u_if.tally_ready = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; (c <= 80) && (done_cyc == 0); c++) begin
      @(negedge clock);
      if (c == 1) begin
        check_val("c1_buttons", {vm_button4, vm_button3, vm_button2, vm_button1}, 4'b0001);
        check_val("c1_mode", vm_mode, 1'b1);
        check_val("c1_busy", busy, 1'b1);
        check_val("c1_winner_valid", winner_valid, 1'b0);
      end
      if (c == 5) begin
        check_val("c5_valid", u_if.tally_valid, 1'b1);
        check_val("c5_count", u_if.tally_count, t0);
      end
      if (pulse && (c == 10)) start = 1'b1;
      if (pulse && (c == 11)) start = 1'b0;
      if (u_if.tally_valid && (u_if.tally_idx == 2'd1) && (stall_left > 0)) begin
        u_if.tally_ready = 1'b0;
        stall_left--;
      end else begin
        u_if.tally_ready = 1'b1;
      end
      if (u_if.tally_valid && u_if.tally_ready) begin
        if (n_xfer < 4) begin
          x_idx[n_xfer] = u_if.tally_idx;
          x_cnt[n_xfer] = u_if.tally_count;
        end
        n_xfer++;
      end
      if (done) begin
        done_cyc = c;
        check_val("done_winner_valid", winner_valid, 1'b1);
        check_val("done_mode", vm_mode, 1'b0);
      end
    end
    check_val("done_cycle", done_cyc, exp_done);
    check_val("xfer_count", n_xfer, 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("xfer%0d_idx", i), x_idx[i], i);
      check_val($sformatf("xfer%0d_cnt", i), x_cnt[i], exp_t[i]);
    end
    check_val("winner", winner, exp_w);
    check_val("tie", tie, exp_tie);
    if (pulse) begin
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      check_val("post_done_busy", busy, 1'b0);
      check_val("post_done_mode", vm_mode, 1'b0);
      check_val("post_done_winner_valid", winner_valid, 1'b1);
    end
  endtask

  initial begin
    vm_tally = '{8'd0, 8'd0, 8'd0, 8'd0};
    u_if.tally_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start = 1'($urandom_range(0, 1));
      u_if.tally_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    check_val("rst_ctrl", {busy, done, vm_mode, winner_valid, winner, tie}, 7'd0);
    check_val("rst_buttons", {vm_button4, vm_button3, vm_button2, vm_button1}, 4'd0);
    check_val("rst_stream", {u_if.tally_valid, u_if.tally_idx, u_if.tally_count}, 11'd0);
    start = 1'b0;
    u_if.tally_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_scan(8'd4, 8'd2, 8'd3, 8'd2, 27, 2'd0, 1'b0, 1'b0, 1'b0);
    run_scan(8'd4, 8'd2, 8'd3, 8'd2, 32, 2'd0, 1'b0, 1'b1, 1'b0);
    run_scan(8'd3, 8'd5, 8'd5, 8'd1, 27, 2'd1, 1'b1, 1'b0, 1'b1);
    run_scan(8'd0, 8'd0, 8'd0, 8'd0, 27, 2'd0, 1'b1, 1'b0, 1'b0);

    // abort during SELECT of candidate 2
    vm_tally = '{8'd7, 8'd7, 8'd7, 8'd7};
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c == 16) begin
        check_val("mid_button3", vm_button3, 1'b1);
        reset = 1'b0;
      end
    end
    @(negedge clock);
    check_val("mid_mode", vm_mode, 1'b0);
    check_val("mid_buttons", {vm_button4, vm_button3, vm_button2, vm_button1}, 4'd0);
    check_val("mid_busy", busy, 1'b0);
    check_val("mid_valid_wv", {u_if.tally_valid, winner_valid}, 2'd0);
    reset = 1'b1;
    run_scan(8'd1, 8'd2, 8'd3, 8'd9, 27, 2'd3, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clock);
    check_val("protocol_monitor", mon_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
